// File: rtl/ram_pkg.sv
// ram_pkg: shared definitions for the data-RAM responder.
//   ram_state_e : responder FSM state encoding (INIT sweep / READY).
//   WORD_W      : data word width in bits.
//   LANE_W      : byte-lane width in bits.
//   NUM_LANES   : byte lanes per word.
package ram_pkg;

    localparam int WORD_W    = 32;
    localparam int LANE_W    = 8;
    localparam int NUM_LANES = WORD_W / LANE_W;

    typedef enum logic {
        RAM_ST_INIT  = 1'b0,
        RAM_ST_READY = 1'b1
    } ram_state_e;

endpackage

// File: rtl/ram_word_array.sv
// ram_word_array: single-port DEPTH x WORD_W storage with per-byte write
// enables and a registered, read-first output.
//   clk     : clock
//   rst     : synchronous active-high reset (clears the output register only)
//   we      : per-lane write enables
//   addr    : word index
//   wdata   : lane-positioned write data
//   rd_en   : load rd_data with the addressed word (pre-write contents)
//   rd_clr  : load rd_data with zero
//   rd_data : registered read data
module ram_word_array
    import ram_pkg::*;
#(
    parameter int DEPTH = 16384,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_LANES-1:0] we,
    input  logic [AW-1:0]        addr,
    input  logic [WORD_W-1:0]    wdata,
    input  logic                 rd_en,
    input  logic                 rd_clr,
    output logic [WORD_W-1:0]    rd_data
);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] rd_data_q;

    // Storage has no reset so it maps onto block RAM; zeroing is done by the
    // responder's init sweep.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (we[i]) begin
                mem[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
            end
        end
    end

    // Non-blocking read of mem in the same edge as the write yields the old
    // contents, giving read-first behaviour.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_clr) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem[addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/data_ram_responder.sv
// data_ram_responder: responder end of the pipeline's data-RAM port.
// After reset it zeroes every word (INIT), then services one access per cycle
// (READY) with byte-lane writes and 1-cycle registered, read-first read data.
//   clk, reset      : clock, synchronous active-high reset
//   data_ram_en     : access request this cycle
//   data_ram_addr   : byte address, word index = addr[31:2]
//   data_ram_w_en   : byte-lane write enables (all zero = read)
//   data_ram_w_data : lane-positioned store data
//   data_ram_r_data : registered read data
//   ram_ready       : init sweep complete
//   addr_err        : sticky, out-of-range access seen
//   align_err       : sticky, misaligned full-word write seen
//
// Interface contract: there is no backpressure. Every request presented with
// data_ram_en=1 while ram_ready=1 is accepted in that cycle; requests while
// ram_ready=0 are discarded without effect.
module data_ram_responder
    import ram_pkg::*;
#(
    parameter int DEPTH = 16384
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 data_ram_en,
    input  logic [31:0]          data_ram_addr,
    input  logic [NUM_LANES-1:0] data_ram_w_en,
    input  logic [WORD_W-1:0]    data_ram_w_data,
    output logic [WORD_W-1:0]    data_ram_r_data,
    output logic                 ram_ready,
    output logic                 addr_err,
    output logic                 align_err
);

    localparam int AW = $clog2(DEPTH);

    ram_state_e state_q, state_d;
    logic [AW-1:0] init_idx_q, init_idx_d;
    logic          addr_err_q, addr_err_d;
    logic          align_err_q, align_err_d;

    logic [29:0]          word_idx;
    logic                 in_range;
    logic                 misaligned;
    logic [NUM_LANES-1:0] arr_we;
    logic [AW-1:0]        arr_addr;
    logic [WORD_W-1:0]    arr_wdata;
    logic                 arr_rd_en;
    logic                 arr_rd_clr;

    always_comb begin
        word_idx    = data_ram_addr[31:2];
        in_range    = (word_idx < 30'(DEPTH));
        misaligned  = (data_ram_w_en == '1) && (data_ram_addr[1:0] != 2'b00);

        state_d     = state_q;
        init_idx_d  = init_idx_q;
        addr_err_d  = addr_err_q;
        align_err_d = align_err_q;
        arr_we      = '0;
        arr_addr    = word_idx[AW-1:0];
        arr_wdata   = data_ram_w_data;
        arr_rd_en   = 1'b0;
        arr_rd_clr  = 1'b0;

        case (state_q)
            RAM_ST_INIT: begin
                arr_we     = '1;
                arr_addr   = init_idx_q;
                arr_wdata  = '0;
                init_idx_d = init_idx_q + 1'b1;
                if (init_idx_q == AW'(DEPTH - 1)) begin
                    state_d = RAM_ST_READY;
                end
            end
            RAM_ST_READY: begin
                if (data_ram_en) begin
                    if (in_range) begin
                        arr_we    = data_ram_w_en;
                        arr_rd_en = 1'b1;
                    end else begin
                        arr_rd_clr = 1'b1;
                        addr_err_d = 1'b1;
                    end
                    // Lanes were already positioned by the initiator, so the
                    // write still goes ahead; only the flag is raised.
                    if (misaligned) begin
                        align_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = RAM_ST_INIT;
            end
        endcase

        // A write presented in a reset cycle (sweep or port) is dropped.
        if (reset) begin
            arr_we = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RAM_ST_INIT;
            init_idx_q  <= '0;
            addr_err_q  <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_idx_q  <= init_idx_d;
            addr_err_q  <= addr_err_d;
            align_err_q <= align_err_d;
        end
    end

    ram_word_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .rst     (reset),
        .we      (arr_we),
        .addr    (arr_addr),
        .wdata   (arr_wdata),
        .rd_en   (arr_rd_en),
        .rd_clr  (arr_rd_clr),
        .rd_data (data_ram_r_data)
    );

    assign ram_ready = (state_q == RAM_ST_READY);
    assign addr_err  = addr_err_q;
    assign align_err = align_err_q;

endmodule

// File: tb/tb_data_ram_responder.sv
module tb_data_ram_responder;

    localparam int DEPTH = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        data_ram_en;
    logic [31:0] data_ram_addr;
    logic [3:0]  data_ram_w_en;
    logic [31:0] data_ram_w_data;
    logic [31:0] data_ram_r_data;
    logic        ram_ready;
    logic        addr_err;
    logic        align_err;

    data_ram_responder #(.DEPTH(DEPTH)) u_dut (
        .clk             (clk),
        .reset           (reset),
        .data_ram_en     (data_ram_en),
        .data_ram_addr   (data_ram_addr),
        .data_ram_w_en   (data_ram_w_en),
        .data_ram_w_data (data_ram_w_data),
        .data_ram_r_data (data_ram_r_data),
        .ram_ready       (ram_ready),
        .addr_err        (addr_err),
        .align_err       (align_err)
    );

    // ---------------- scoreboard state ----------------
    int          checks;
    int          failures;
    logic [31:0] exp_q[$];
    logic [31:0] model [DEPTH];
    logic [31:0] last_exp;
    logic        exp_addr_err;
    logic        exp_align_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
        last_exp      = 32'h0;
        exp_addr_err  = 1'b0;
        exp_align_err = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        reset       = 1'b1;
        data_ram_en = 1'b0;
        tick();
        tick();
        model_clear();
        check("rst_r_data", data_ram_r_data, 32'h0);
        check("rst_ready", {31'b0, ram_ready}, 32'h0);
        check("rst_addr_err", {31'b0, addr_err}, 32'h0);
        check("rst_align_err", {31'b0, align_err}, 32'h0);
    endtask

    // Counts cycles (continuing from 'start') until ram_ready, bounded.
    task automatic wait_ready(input string tag, input int start);
        int n;
        n = start;
        while (!ram_ready && n < 64) begin
            tick();
            n++;
        end
        check(tag, 32'(n), 32'(DEPTH));
    endtask

    // One READY-state access; expected r_data and flags come from the model.
    task automatic access(input string tag, input logic [31:0] addr,
                          input logic [3:0] we, input logic [31:0] wd);
        logic [29:0] idx;
        logic [31:0] got;
        idx = addr[31:2];
        if (idx >= 30'(DEPTH)) begin
            exp_q.push_back(32'h0);
            exp_addr_err = 1'b1;
        end else begin
            exp_q.push_back(model[idx]);
            for (int i = 0; i < 4; i++)
                if (we[i]) model[idx][i*8 +: 8] = wd[i*8 +: 8];
        end
        if (we == 4'hF && addr[1:0] != 2'b00) exp_align_err = 1'b1;

        data_ram_en     = 1'b1;
        data_ram_addr   = addr;
        data_ram_w_en   = we;
        data_ram_w_data = wd;
        tick();
        data_ram_en = 1'b0;

        got      = data_ram_r_data;
        last_exp = exp_q.pop_front();
        check({tag, "_rdata"}, got, last_exp);
        check({tag, "_addr_err"}, {31'b0, addr_err}, {31'b0, exp_addr_err});
        check({tag, "_align_err"}, {31'b0, align_err}, {31'b0, exp_align_err});
    endtask

    task automatic idle(input string tag);
        data_ram_en     = 1'b0;
        data_ram_addr   = $urandom;
        data_ram_w_en   = 4'($urandom_range(0, 15));
        data_ram_w_data = $urandom;
        tick();
        check({tag, "_hold"}, data_ram_r_data, last_exp);
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < DEPTH; i++) access(tag, 32'(i * 4), 4'h0, 32'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        checks          = 0;
        failures        = 0;
        data_ram_en     = 1'b0;
        data_ram_addr   = '0;
        data_ram_w_en   = '0;
        data_ram_w_data = '0;
        apply_reset();

        // Init sweep with an ignored write attempt at sweep cycle 5.
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        data_ram_en     = 1'b1;
        data_ram_addr   = 32'h14;
        data_ram_w_en   = 4'hF;
        data_ram_w_data = 32'hFFFFFFFF;
        tick();
        data_ram_en = 1'b0;
        check("init_write_rdata", data_ram_r_data, 32'h0);
        check("init_not_ready", {31'b0, ram_ready}, 32'h0);
        wait_ready("init_latency", 6);
        access("rd_word5", 32'h14, 4'h0, 32'h0);

        // Full-word write then byte merge.
        access("wr_40", 32'h40 - 32'h40 + 32'h40 & 32'h3C, 4'hF, 32'h11223344);
        access("wr_41", 32'h41 & 32'h3F, 4'b0010, 32'h0000AA00);
        access("rd_40", 32'h00, 4'h0, 32'h0);
        check("merge_value", model[0], 32'h1122AA44);
        check("merge_rdata", last_exp, 32'h1122AA44);

        // Read-first hazard and back-to-back store->load.
        access("wr_8", 32'h8, 4'hF, 32'hDEADBEEF);
        check("rf_old", data_ram_r_data, 32'h0);
        access("rd_8", 32'h8, 4'h0, 32'h0);
        check("rf_new", data_ram_r_data, 32'hDEADBEEF);
        idle("idle_a");
        idle("idle_b");

        // Misaligned full-word write: flag set, word 1 still updated.
        access("mis_6", 32'h6, 4'hF, 32'hCAFEF00D);
        access("rd_4", 32'h4, 4'h0, 32'h0);
        check("mis_word1", data_ram_r_data, 32'hCAFEF00D);
        check("mis_no_addr_err", {31'b0, addr_err}, 32'h0);

        // Random in-range traffic.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) idle("rnd_idle");
            else access("rnd", 32'($urandom_range(0, 4 * DEPTH - 1)),
                        4'($urandom_range(0, 15)), $urandom);
        end

        // Out-of-range write: r_data forced to 0, nothing stored.
        access("rd_8b", 32'h8, 4'h0, 32'h0);
        access("oor_40", 32'h40, 4'hF, 32'hFFFFFFFF);
        check("oor_rdata", data_ram_r_data, 32'h0);
        check("oor_flag", {31'b0, addr_err}, 32'h1);
        access("oor_hi", 32'h8000_0000, 4'h0, 32'h0);
        read_all("oor_scan");

        // Mid-sweep reset: sweep restarts and flags clear.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("msr_not_ready", {31'b0, ram_ready}, 32'h0);
        check("msr_addr_err", {31'b0, addr_err}, 32'h0);
        check("msr_align_err", {31'b0, align_err}, 32'h0);
        wait_ready("msr_latency", 0);
        model_clear();
        read_all("msr_scan");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
